// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use / MDU hazard detection, branch flush control and
// the busy countdown of the shared multi-cycle multiply/divide unit.
// Optional build macro HAZARD_PERF_EN adds saturating stall/flush counters.
module hazard_stall_ctrl #(
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_Ra,
  input  logic [4:0] id_Rb,
  input  logic       id_UseRb,
  input  logic       id_MduOp,
  input  logic       id_MduRead,
  input  logic [4:0] ex_Rw,
  input  logic       ex_MemRead,
  input  logic       ex_BranchTaken,
`ifdef HAZARD_PERF_EN
  output logic [15:0] perf_stall_cnt,
  output logic [15:0] perf_flush_cnt,
`endif
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       mdu_start,
  output logic       mdu_busy
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  logic             state;
  logic [CNT_W-1:0] cnt;
  logic             lu;
  logic             mh;
  logic             stl;

  // Hazard detection and pipeline control; a taken branch squashes ID, so it
  // overrides any stall in the same cycle.
  always_comb begin
    lu = ex_MemRead && (ex_Rw != 5'd0) &&
         ((ex_Rw == id_Ra) || (id_UseRb && (ex_Rw == id_Rb)));
    mdu_busy   = (state == ST_BUSY);
    mh         = mdu_busy && (id_MduRead || id_MduOp);
    stl        = (lu || mh) && !ex_BranchTaken;
    pc_write   = !stl;
    ifid_write = !stl;
    idex_flush = stl || ex_BranchTaken;
    ifid_flush = ex_BranchTaken;
    mdu_start  = (state == ST_IDLE) && id_MduOp && !ex_BranchTaken && !lu;
  end

  // MDU busy countdown; once issued it always runs to completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mdu_start) begin
            state <= ST_BUSY;
            cnt   <= CNT_W'(MDU_LAT - 1);
          end
        end
        default: begin
          // counter==0 cannot occur in BUSY; treat it like completion
          if (cnt == CNT_W'(1) || cnt == '0) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  // Saturating event counters for stall and flush cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stl && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      if (ex_BranchTaken && perf_flush_cnt != '1)
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed testbench for hazard_stall_ctrl with MDU_LAT=4.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_Ra, id_Rb, ex_Rw;
  logic       id_UseRb, id_MduOp, id_MduRead, ex_MemRead, ex_BranchTaken;
  logic       pc_write, ifid_write, ifid_flush, idex_flush, mdu_start, mdu_busy;
`ifdef HAZARD_PERF_EN
  logic [15:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MDU_LAT(4), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .id_Ra(id_Ra), .id_Rb(id_Rb), .id_UseRb(id_UseRb),
    .id_MduOp(id_MduOp), .id_MduRead(id_MduRead),
    .ex_Rw(ex_Rw), .ex_MemRead(ex_MemRead), .ex_BranchTaken(ex_BranchTaken),
`ifdef HAZARD_PERF_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .mdu_start(mdu_start), .mdu_busy(mdu_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_inputs();
    id_Ra = '0; id_Rb = '0; id_UseRb = 1'b0; id_MduOp = 1'b0; id_MduRead = 1'b0;
    ex_Rw = '0; ex_MemRead = 1'b0; ex_BranchTaken = 1'b0;
  endtask

  // advance to just after the next rising edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // {pc_write, ifid_write, ifid_flush, idex_flush}
  task automatic check_ctl(input string tag, input logic [3:0] exp);
    #1;
    check(tag, {28'd0, pc_write, ifid_write, ifid_flush, idex_flush}, {28'd0, exp});
  endtask

  initial begin
    clr_inputs();
    rst = 1'b1;
    #1;
    check("rst_ctl", {28'd0, pc_write, ifid_write, ifid_flush, idex_flush}, 32'h0000_000C);
    check("rst_mdu", {30'd0, mdu_start, mdu_busy}, 32'd0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // 1: load-use on rs
    ex_MemRead = 1'b1; ex_Rw = 5'd5; id_Ra = 5'd5;
    check_ctl("lu_stall", 4'b0001);
    next_cycle();
    ex_MemRead = 1'b0;
    check_ctl("lu_clear", 4'b1100);

    // 2: load to $0, and rt match without UseRb
    next_cycle();
    ex_MemRead = 1'b1; ex_Rw = 5'd0; id_Ra = 5'd0;
    check_ctl("lu_r0", 4'b1100);
    ex_Rw = 5'd5; id_Ra = 5'd3; id_Rb = 5'd5; id_UseRb = 1'b0;
    check_ctl("lu_rb_unused", 4'b1100);
    id_UseRb = 1'b1;
    check_ctl("lu_rb_used", 4'b0001);

    // 3: taken branch beats stall
    ex_BranchTaken = 1'b1;
    check_ctl("br_over_lu", 4'b1111);
    id_MduOp = 1'b1;
    #1 check("br_cancel_issue", {31'd0, mdu_start}, 32'd0);
    // load-use blocks MDU issue; issues once the hazard clears
    ex_BranchTaken = 1'b0;
    #1 check("lu_block_issue", {31'd0, mdu_start}, 32'd0);
    next_cycle();
    check("br_no_busy", {31'd0, mdu_busy}, 32'd0);
    ex_MemRead = 1'b0;
    #1 check("issue_after_lu", {31'd0, mdu_start}, 32'd1);
    next_cycle();
    clr_inputs();
    repeat (4) next_cycle();

    // 4: MDU issue then dependent HI/LO read
    id_MduOp = 1'b1;
    #1 check("mdu_c0_start", {30'd0, mdu_start, mdu_busy}, 32'b10);
    next_cycle();
    id_MduOp = 1'b0; id_MduRead = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      #1 check($sformatf("mdu_c%0d_busy", i), {30'd0, mdu_start, mdu_busy}, 32'b01);
      check_ctl($sformatf("mdu_c%0d_ctl", i), 4'b0001);
      next_cycle();
    end
    #1 check("mdu_c4_idle", {30'd0, mdu_start, mdu_busy}, 32'b00);
    check_ctl("mdu_c4_ctl", 4'b1100);
    clr_inputs();
    next_cycle();

    // 5: back-to-back MDU ops
    id_MduOp = 1'b1;
    #1 check("b2b_c0_start", {31'd0, mdu_start}, 32'd1);
    next_cycle();
    for (int i = 1; i <= 3; i++) begin
      #1 check($sformatf("b2b_c%0d_start", i), {31'd0, mdu_start}, 32'd0);
      check_ctl($sformatf("b2b_c%0d_ctl", i), 4'b0001);
      next_cycle();
    end
    #1 check("b2b_c4_start", {31'd0, mdu_start}, 32'd1);
    check_ctl("b2b_c4_ctl", 4'b1100);
    next_cycle();
    id_MduOp = 1'b0;
    #1 check("b2b_c5_busy", {31'd0, mdu_busy}, 32'd1);

    // 6: reset mid-countdown (op above issued at c4, now c5=1, c6=2)
    next_cycle();
    id_MduRead = 1'b1;
    check_ctl("rstmid_pre_stall", 4'b0001);
    rst = 1'b1;
    #1 check("rstmid_busy", {31'd0, mdu_busy}, 32'd0);
    check_ctl("rstmid_ctl", 4'b1100);
    #1 rst = 1'b0;
    next_cycle();
    #1 check("rstpost_busy", {31'd0, mdu_busy}, 32'd0);
    check_ctl("rstpost_ctl", 4'b1100);
    clr_inputs();

`ifdef HAZARD_PERF_EN
    next_cycle();
    check("perf_stall_rst", {16'd0, perf_stall_cnt}, 32'd0);
    id_MduOp = 1'b1;
    ex_BranchTaken = 1'b1;
    next_cycle();
    ex_BranchTaken = 1'b0;
    next_cycle();
    id_MduOp = 1'b0; id_MduRead = 1'b1;
    repeat (3) next_cycle();
    #1 check("perf_stall_3", {16'd0, perf_stall_cnt}, 32'd3);
    check("perf_flush_1", {16'd0, perf_flush_cnt}, 32'd1);
    rst = 1'b1;
    #1 check("perf_stall_clr", {16'd0, perf_stall_cnt}, 32'd0);
    check("perf_flush_clr", {16'd0, perf_flush_cnt}, 32'd0);
    rst = 1'b0;
    clr_inputs();
`endif

    next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline hazard and stall sequencer for the 5-stage MIPS core; it works alongside the EX-stage forwarding logic.
- Detects load-use hazards in ID and inserts bubbles.
- Flushes IF/ID and ID/EX on a taken branch or jump resolved in EX.
- Owns the busy countdown of the shared multi-cycle multiply/divide unit (MDU) and stalls ID when a dependent HI/LO read or a second MDU op arrives early.
- Drives the PC write enable, IF/ID write enable and both flush controls.

Parameters:
MDU_LAT, 32, cycles from MDU issue until HI/LO valid (legal range 2..63)
CNT_W, 6, width of MDU countdown counter; must satisfy 2^CNT_W > MDU_LAT

Ports:
clk  in  1  core clock, rising edge
rst  in  1  reset, asynchronous, active-high
id_Ra  in  5  rs field of instruction in ID
id_Rb  in  5  rt field of instruction in ID
id_UseRb  in  1  ID instruction reads rt as a source
id_MduOp  in  1  ID instruction is mult/multu/div/divu
id_MduRead  in  1  ID instruction is mfhi/mflo/mthi/mtlo
ex_Rw  in  5  destination register of instruction in EX
ex_MemRead  in  1  EX instruction is a load
ex_BranchTaken  in  1  branch/jump resolved taken in EX
pc_write  out  1  PC register load enable
ifid_write  out  1  IF/ID register load enable
ifid_flush  out  1  clear IF/ID to nop
idex_flush  out  1  clear ID/EX to nop (bubble)
mdu_start  out  1  one-cycle issue strobe to MDU
mdu_busy  out  1  MDU result not yet valid

Behaviour:
- Reset state (asynchronous, while rst=1):
  - pc_write=1, ifid_write=1, ifid_flush=0, idex_flush=0, mdu_start=0, mdu_busy=0.
  - State IDLE, counter=0.
- Load-use hazard `lu`: ex_MemRead=1 AND ex_Rw!=0 AND (ex_Rw==id_Ra OR (id_UseRb=1 AND ex_Rw==id_Rb)).
- MDU hazard `mh`: mdu_busy=1 AND (id_MduRead=1 OR id_MduOp=1).
- Stall `stl` = (lu OR mh) AND NOT ex_BranchTaken.
- Combinational outputs, evaluated every cycle:
  - pc_write = ifid_write = NOT stl.
  - idex_flush = stl OR ex_BranchTaken.
  - ifid_flush = ex_BranchTaken.
- Priority: a taken branch beats any stall. The ID instruction is squashed by the flush, so no stall is applied in that cycle.
- MDU state machine, two states:
  - IDLE:
    - mdu_busy=0.
    - If id_MduOp=1 AND NOT ex_BranchTaken AND NOT lu: mdu_start=1 this cycle, counter <= MDU_LAT-1, next state BUSY.
  - BUSY:
    - mdu_busy=1.
    - Counter decrements each cycle.
    - When counter==1: next state IDLE, counter <= 0. mdu_busy is therefore 0 in the cycle MDU_LAT after the issue cycle.
    - mdu_start is never asserted in BUSY. A second MDU op is held in ID by `mh` until IDLE, and issues in that first IDLE cycle.
- A load-use stall blocks MDU issue that cycle. The op re-evaluates the next cycle, when the bubble has cleared the hazard.
- A branch flush in the issue cycle cancels the issue: no mdu_start, state stays IDLE.
- Once issued, the MDU op is never cancelled by a later flush; the countdown always completes.
- Counter arithmetic is unsigned CNT_W-bit. Decrement below 0 is unreachable. Counter==0 in BUSY is illegal; recover to IDLE on the next edge.
- rst asserted mid-countdown: immediately IDLE, mdu_busy=0, counter=0.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds outputs perf_stall_cnt (16 bits) and perf_flush_cnt (16 bits).
  - perf_stall_cnt increments on each cycle with stl=1.
  - perf_flush_cnt increments on each cycle with ex_BranchTaken=1.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: neither port nor either counter exists; all other behaviour is identical.

Test Plan:
1. Load-use: ex_MemRead=1, ex_Rw=5, id_Ra=5 -> that cycle pc_write=0, ifid_write=0, idex_flush=1. Next cycle, with ex_MemRead=0: all back to 1/1/0.
2. Load to $0: ex_MemRead=1, ex_Rw=0, id_Ra=0 -> no stall (pc_write=1, idex_flush=0). Also id_Rb=5 matching ex_Rw=5 with id_UseRb=0 -> no stall.
3. Branch beats stall: lu condition true with ex_BranchTaken=1 -> pc_write=1, ifid_flush=1, idex_flush=1.
4. MDU sequence, MDU_LAT=4: id_MduOp at cycle 0 -> mdu_start=1 at cycle 0, mdu_busy=1 in cycles 1-3. id_MduRead held from cycle 1 -> pc_write=0 in cycles 1-3, pc_write=1 at cycle 4.
5. Back-to-back MDU ops: second id_MduOp held from cycle 1 -> stalled in cycles 1-3, mdu_start=1 at cycle 4.
6. rst pulsed at cycle 2 of the MDU countdown -> mdu_busy=0 immediately; no stall after reset. With HAZARD_PERF_EN: 3 stall cycles then reset -> perf_stall_cnt reads 3 before reset and 0 after.
